// File: rtl/recirc_pkg.sv
// recirc_pkg: shared state encoding and default sizing for the recirculation merge path
package recirc_pkg;
  typedef enum logic [1:0] {GEN, LOOP, DRAIN, GUARD} state_e;
  localparam int LANES = 4;
  localparam int DEF_DATA_W = 8;
  localparam int DEF_FIFO_DEPTH = 4;
  localparam int DEF_GUARD_CYCLES = 2;
endpackage

// File: rtl/recirc_merge_lane_fifo.sv
// lane_fifo: per-lane elastic FIFO with flush, occupancy count and drop-on-full overflow pulse
module lane_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic push,
  input  logic pop,
  input  logic flush,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout,
  output logic empty,
  output logic full,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic ovf
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];
  logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0] count_q, count_d;
  logic wr, rd;
  assign empty = count_q == '0;
  assign full = count_q == CW'(DEPTH);
  assign count = count_q;
  assign dout = mem_q[rd_q];
  // a pop frees the slot in the same cycle, so push+pop on a full FIFO is accepted
  always_comb begin
    rd = pop && !empty;
    wr = push && (!full || rd);
    ovf = push && full && !rd;
    mem_d = mem_q;
    if (wr) mem_d[wr_q] = din;
    wr_d = flush ? '0 : wr_q + PW'(wr);
    rd_d = flush ? '0 : rd_q + PW'(rd);
    count_d = flush ? '0 : count_q + CW'(wr) - CW'(rd);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_q <= '0;
      rd_q <= '0;
      count_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
      count_q <= count_d;
    end
  end
  always_ff @(posedge clk) mem_q <= mem_d;
endmodule

// File: rtl/recirc_merge.sv
// recirc_merge: merges deskewed loopback lanes and generator lanes into one 4-lane stream with drain/guard switching
module recirc_merge
  import recirc_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
  parameter int GUARD_CYCLES = DEF_GUARD_CYCLES
) (
  input  logic clk,
  input  logic reset,
  input  logic recirculacion,
  input  logic [DATA_W-1:0] loop_data0,
  input  logic [DATA_W-1:0] loop_data1,
  input  logic [DATA_W-1:0] loop_data2,
  input  logic [DATA_W-1:0] loop_data3,
  input  logic loop_valid0,
  input  logic loop_valid1,
  input  logic loop_valid2,
  input  logic loop_valid3,
  input  logic [DATA_W-1:0] gen_data0,
  input  logic [DATA_W-1:0] gen_data1,
  input  logic [DATA_W-1:0] gen_data2,
  input  logic [DATA_W-1:0] gen_data3,
  input  logic gen_valid0,
  input  logic gen_valid1,
  input  logic gen_valid2,
  input  logic gen_valid3,
  output logic [DATA_W-1:0] data_out0,
  output logic [DATA_W-1:0] data_out1,
  output logic [DATA_W-1:0] data_out2,
  output logic [DATA_W-1:0] data_out3,
  output logic valid_out0,
  output logic valid_out1,
  output logic valid_out2,
  output logic valid_out3,
  output logic recirc_active,
  output logic switch_busy,
  output logic [3:0] overflow
);
  localparam int CW = $clog2(FIFO_DEPTH+1);
  localparam int GW = (GUARD_CYCLES > 1) ? $clog2(GUARD_CYCLES) : 1;
  state_e state_q, state_d, target_q, target_d;
  logic sel_q;
  logic [GW-1:0] gcnt_q, gcnt_d;
  logic [DATA_W-1:0] loop_in [LANES];
  logic [DATA_W-1:0] gen_in [LANES];
  logic [DATA_W-1:0] head [LANES];
  logic [DATA_W-1:0] data_q [LANES];
  logic [DATA_W-1:0] data_d [LANES];
  logic [LANES-1:0] loop_v, gen_v, valid_q, valid_d, empty_w, full_w, ovf_w, overflow_q, overflow_d;
  logic [CW-1:0] count_w [LANES];
  logic all_ne, pop_all, flush, guard_done, unused_fifo;
  assign loop_in = '{loop_data0, loop_data1, loop_data2, loop_data3};
  assign gen_in = '{gen_data0, gen_data1, gen_data2, gen_data3};
  assign loop_v = {loop_valid3, loop_valid2, loop_valid1, loop_valid0};
  assign gen_v = {gen_valid3, gen_valid2, gen_valid1, gen_valid0};
  assign all_ne = ~|empty_w;
  assign pop_all = (state_q == LOOP || state_q == DRAIN) && all_ne;
  // FIFOs stay empty outside LOOP; a DRAIN ends by discarding any unmatched residue
  assign flush = state_q == GEN || state_q == GUARD || (state_q == DRAIN && !all_ne);
  assign guard_done = gcnt_q == GW'(GUARD_CYCLES-1);
  assign unused_fifo = ^{full_w, count_w[0], count_w[1], count_w[2], count_w[3]};
  for (genvar g = 0; g < LANES; g++) begin : g_lane
    lane_fifo #(.DATA_W(DATA_W), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clk(clk), .reset(reset), .push(state_q == LOOP && loop_v[g]), .pop(pop_all), .flush(flush),
      .din(loop_in[g]), .dout(head[g]), .empty(empty_w[g]), .full(full_w[g]), .count(count_w[g]), .ovf(ovf_w[g])
    );
  end
  always_comb begin
    state_d = state_q;
    target_d = target_q;
    gcnt_d = gcnt_q;
    case (state_q)
      GEN: if (sel_q) begin state_d = GUARD; target_d = LOOP; end
      LOOP: if (!sel_q) begin state_d = DRAIN; target_d = GEN; end
      DRAIN: if (!all_ne) state_d = GUARD;
      GUARD: begin
        gcnt_d = guard_done ? '0 : gcnt_q + 1'b1;
        state_d = guard_done ? target_q : GUARD;
      end
      default: state_d = GEN;
    endcase
    overflow_d = overflow_q | ovf_w;
    for (int i = 0; i < LANES; i++) begin
      valid_d[i] = (state_q == GEN) ? gen_v[i] : pop_all;
      data_d[i] = (state_q == GEN) ? gen_in[i] : (pop_all ? head[i] : '0);
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= GEN;
      target_q <= GEN;
      sel_q <= 1'b0;
      gcnt_q <= '0;
      overflow_q <= '0;
      valid_q <= '0;
      data_q <= '{default: '0};
    end else begin
      state_q <= state_d;
      target_q <= target_d;
      sel_q <= recirculacion;
      gcnt_q <= gcnt_d;
      overflow_q <= overflow_d;
      valid_q <= valid_d;
      data_q <= data_d;
    end
  end
  assign {valid_out3, valid_out2, valid_out1, valid_out0} = valid_q;
  assign data_out0 = data_q[0];
  assign data_out1 = data_q[1];
  assign data_out2 = data_q[2];
  assign data_out3 = data_q[3];
  assign recirc_active = state_q == LOOP;
  assign switch_busy = state_q == DRAIN || state_q == GUARD;
  assign overflow = overflow_q;
endmodule

// File: tb/tb_recirc_merge.sv
// tb_recirc_merge: directed test-plan scenarios plus random traffic against a queue-based reference model
module tb_recirc_merge;
  localparam int D = 4;
  localparam int G = 2;
  localparam int M_GEN = 0, M_LOOP = 1, M_DRAIN = 2, M_GUARD = 3;
  logic clk = 1'b0;
  logic reset, recirculacion;
  logic [7:0] ld [4];
  logic [7:0] gd [4];
  logic [3:0] lv, gv;
  logic [7:0] data_out0, data_out1, data_out2, data_out3;
  logic valid_out0, valid_out1, valid_out2, valid_out3;
  logic recirc_active, switch_busy;
  logic [3:0] overflow;
  logic [7:0] dout [4];
  logic [3:0] vout;
  int n_cmp = 0, n_err = 0;
  int mode, tgt, gleft;
  logic sel;
  logic [7:0] q [4][$];
  logic [7:0] ed [4];
  logic [3:0] ev, eovf;
  always #5 clk = ~clk;
  recirc_merge #(.DATA_W(8), .FIFO_DEPTH(D), .GUARD_CYCLES(G)) dut (
    .clk(clk), .reset(reset), .recirculacion(recirculacion),
    .loop_data0(ld[0]), .loop_data1(ld[1]), .loop_data2(ld[2]), .loop_data3(ld[3]),
    .loop_valid0(lv[0]), .loop_valid1(lv[1]), .loop_valid2(lv[2]), .loop_valid3(lv[3]),
    .gen_data0(gd[0]), .gen_data1(gd[1]), .gen_data2(gd[2]), .gen_data3(gd[3]),
    .gen_valid0(gv[0]), .gen_valid1(gv[1]), .gen_valid2(gv[2]), .gen_valid3(gv[3]),
    .data_out0(data_out0), .data_out1(data_out1), .data_out2(data_out2), .data_out3(data_out3),
    .valid_out0(valid_out0), .valid_out1(valid_out1), .valid_out2(valid_out2), .valid_out3(valid_out3),
    .recirc_active(recirc_active), .switch_busy(switch_busy), .overflow(overflow)
  );
  assign dout[0] = data_out0;
  assign dout[1] = data_out1;
  assign dout[2] = data_out2;
  assign dout[3] = data_out3;
  assign vout = {valid_out3, valid_out2, valid_out1, valid_out0};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: one clock edge of the merge behaviour, using per-lane byte queues
  task automatic model();
    logic pop;
    if (reset) begin
      mode = M_GEN; tgt = M_GEN; gleft = 0; sel = 1'b0; eovf = '0; ev = '0;
      for (int i = 0; i < 4; i++) begin ed[i] = '0; q[i].delete(); end
      return;
    end
    pop = (mode == M_LOOP || mode == M_DRAIN) && q[0].size() > 0 && q[1].size() > 0 && q[2].size() > 0 && q[3].size() > 0;
    ev = '0;
    for (int i = 0; i < 4; i++) ed[i] = '0;
    if (mode == M_GEN) begin
      ev = gv;
      for (int i = 0; i < 4; i++) ed[i] = gd[i];
    end else if (pop) begin
      ev = 4'hf;
      for (int i = 0; i < 4; i++) ed[i] = q[i].pop_front();
    end
    if (mode == M_LOOP)
      for (int i = 0; i < 4; i++)
        if (lv[i]) begin
          if (q[i].size() < D) q[i].push_back(ld[i]);
          else eovf[i] = 1'b1;
        end
    case (mode)
      M_GEN: if (sel) begin mode = M_GUARD; tgt = M_LOOP; gleft = G; end
      M_LOOP: if (!sel) begin mode = M_DRAIN; tgt = M_GEN; end
      M_DRAIN: if (!pop) begin
        for (int i = 0; i < 4; i++) q[i].delete();
        mode = M_GUARD; gleft = G;
      end
      default: begin gleft--; if (gleft == 0) mode = tgt; end
    endcase
    sel = recirculacion;
  endtask

  task automatic cyc();
    @(posedge clk);
    model();
    #1;
    for (int i = 0; i < 4; i++) chk($sformatf("data%0d", i), dout[i], ed[i]);
    chk("valid", vout, ev);
    chk("active", recirc_active, mode == M_LOOP);
    chk("busy", switch_busy, mode == M_DRAIN || mode == M_GUARD);
    chk("ovf", overflow, eovf);
  endtask

  task automatic rnd_data();
    for (int i = 0; i < 4; i++) begin ld[i] = 8'($urandom); gd[i] = 8'($urandom); end
  endtask

  initial begin
    int cnt;
    logic [3:0] vacc;
    reset = 1'b1; recirculacion = 1'b0; lv = '0; gv = '0;
    for (int i = 0; i < 4; i++) begin ld[i] = '0; gd[i] = '0; end
    cyc(); cyc();
    chk("rst_valid", vout, 4'h0);
    chk("rst_ovf", overflow, 4'h0);
    reset = 1'b0;
    // generator passthrough with loop inputs toggling
    gd = '{8'h11, 8'h22, 8'h33, 8'h44}; gv = 4'hf; lv = 4'hf;
    for (int i = 0; i < 4; i++) ld[i] = 8'($urandom);
    cyc();
    chk("gen_d0", dout[0], 8'h11);
    chk("gen_d3", dout[3], 8'h44);
    chk("gen_v", vout, 4'hf);
    lv = 4'h5; rnd_data(); cyc();
    // switch to loopback
    gv = '0; lv = '0; recirculacion = 1'b1;
    cyc(); chk("busy_t1", switch_busy, 1'b0);
    cyc(); chk("busy_t2", switch_busy, 1'b1);
    cyc(); chk("busy_t3", switch_busy, 1'b1);
    cyc(); chk("active_t4", recirc_active, 1'b1);
    ld = '{8'hA0, 8'hA1, 8'hA2, 8'hA3}; lv = 4'hf;
    cyc(); lv = '0;
    chk("loop_t5_v", vout, 4'h0);
    cyc();
    chk("loop_t6_v", vout, 4'hf);
    chk("loop_t6_d0", dout[0], 8'hA0);
    chk("loop_t6_d3", dout[3], 8'hA3);
    // lane 3 skewed by 3 cycles: no loss
    cnt = 0;
    for (int k = 0; k < 10; k++) begin
      lv = (k < 6) ? {k >= 3, {3{k < 3}}} : 4'h0;
      rnd_data(); cyc();
      cnt += (vout == 4'hf) ? 1 : 0;
    end
    chk("skew3_words", cnt, 3);
    chk("skew3_ovf", overflow, 4'h0);
    // lane 3 skewed by 5 cycles: lanes 0-2 overflow
    for (int k = 0; k < 13; k++) begin
      lv = (k < 9) ? {k >= 5, {3{k < 5}}} : 4'h0;
      rnd_data(); cyc();
    end
    chk("skew5_ovf", overflow, 4'h7);
    // LOOP to GEN with two aligned words and one extra lane-0 byte buffered
    cnt = 0;
    lv = 4'b0111; rnd_data(); cyc(); cnt += (vout == 4'hf) ? 1 : 0;
    lv = 4'b0111; rnd_data(); cyc(); cnt += (vout == 4'hf) ? 1 : 0;
    lv = 4'b1001; recirculacion = 1'b0; rnd_data(); cyc(); cnt += (vout == 4'hf) ? 1 : 0;
    lv = 4'b1000; rnd_data(); cyc(); cnt += (vout == 4'hf) ? 1 : 0;
    lv = '0;
    for (int k = 0; k < 6; k++) begin rnd_data(); cyc(); cnt += (vout == 4'hf) ? 1 : 0; end
    chk("drain_words", cnt, 2);
    chk("back_in_gen", {recirc_active, switch_busy}, 2'b00);
    gd = '{8'h71, 8'h72, 8'h73, 8'h74}; gv = 4'hf; cyc();
    chk("post_drain_gen", dout[1], 8'h72);
    // toggles during GUARD must not disturb the switch
    gv = '0; vacc = '0; recirculacion = 1'b1;
    cyc(); vacc |= vout;
    cyc(); vacc |= vout;
    recirculacion = 1'b0; cyc(); vacc |= vout;
    recirculacion = 1'b1; cyc(); vacc |= vout;
    cyc(); vacc |= vout;
    chk("toggle_active", recirc_active, 1'b1);
    chk("toggle_noglitch", vacc, 4'h0);
    // reset asserted during DRAIN
    lv = 4'b0111; rnd_data(); cyc(); cyc(); cyc();
    lv = 4'b1000; recirculacion = 1'b0; cyc(); cyc();
    lv = '0; cyc();
    chk("pre_reset_drain", switch_busy, 1'b1);
    reset = 1'b1; gv = 4'hf; rnd_data(); cyc();
    chk("rst_mid_ovf", overflow, 4'h0);
    chk("rst_mid_state", {recirc_active, switch_busy}, 2'b00);
    chk("rst_mid_valid", vout, 4'h0);
    chk("rst_mid_d0", dout[0], 8'h00);
    reset = 1'b0; gd = '{8'h5A, 8'h5B, 8'h5C, 8'h5D}; gv = 4'hf; cyc();
    chk("post_rst_gen", dout[0], 8'h5A);
    // random traffic
    for (int k = 0; k < 1500; k++) begin
      if ($urandom_range(0, 24) == 0) recirculacion = ~recirculacion;
      reset = ($urandom_range(0, 399) == 0);
      lv = ($urandom_range(0, 2) != 0) ? 4'hf : 4'($urandom);
      if ($urandom_range(0, 3) == 0) lv = '0;
      gv = 4'($urandom);
      rnd_data();
      cyc();
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
